tx_frame_sequencer: RTL and testbench
=====================================

Name: tx_frame_sequencer

Overview:
- Front-end controller for the 802.11a transmit chain. Accepts one frame request (RATE, LENGTH) and a byte stream of PSDU data.
- Computes N_SYM and N_PAD, then emits the bit-serial sequence SIGNAL(24) → SERVICE(16) → PSDU(8·LENGTH) → TAIL(6) → PAD(N_PAD) with a valid/ready handshake.
- Drives scrambler reset/enable and tail-zeroing controls, so the scrambler, encoder and interleaver run from one sequencer.

Parameters:
- MAX_LEN, 4095, largest accepted LENGTH in bytes; larger requests are rejected.
- CNT_W, 16, width of the internal bit counter; must hold 22+8·MAX_LEN.

Ports:
- Clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  frame request strobe; sampled only in IDLE.
- rate  in  4  RATE code R1..R4 = rate[3:0]; captured on start.
- length  in  12  PSDU length in bytes; captured on start.
- byte_in  in  8  PSDU byte; LSB is transmitted first.
- byte_valid  in  1  byte_in valid.
- byte_ready  out  1  byte accepted when byte_valid&byte_ready.
- bit_out  out  1  serial bit to the scrambler/encoder path.
- bit_valid  out  1  bit_out valid.
- bit_ready  in  1  downstream accepts; a beat occurs when bit_valid&bit_ready.
- scr_rst  out  1  one-cycle pulse: load the scrambler seed.
- scr_en  out  1  scrambler advances; equals a beat in SERVICE/PSDU/TAIL/PAD.
- tail_zero  out  1  high during TAIL; downstream forces scrambled bits to 0.
- n_pad  out  8  computed pad bits; valid from end of CALC until next start.
- n_sym  out  11  computed OFDM data symbols.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse after the last PAD beat.
- err  out  1  one-cycle pulse on a rejected request.

Behaviour:
- Reset: state=IDLE. All outputs are 0: byte_ready, bit_out, bit_valid, scr_rst, scr_en, tail_zero, n_pad, n_sym, busy, done, err. Counters and shift registers are cleared.
- N_DBPS lookup:
  - 1101→24, 1111→36, 0101→48, 0111→72
  - 1001→96, 1011→144, 0001→192, 0011→216
  - Any other code is invalid.
- IDLE:
  - On start with an invalid rate, or length==0, or length>MAX_LEN: err pulses the next cycle and the state stays IDLE.
  - Otherwise latch rate and length, set nbits=22+8·length, clear acc/nsym, and go to CALC.
  - start in any other state is ignored.
- CALC:
  - Each cycle: acc+=N_DBPS, nsym+=1.
  - When the updated acc≥nbits: n_pad=acc−nbits, n_sym=nsym; build the SIGNAL word; enter SIGNAL.
  - Latency is n_sym cycles, with no divider.
- SIGNAL word, bit index = transmit order:
  - b0..b3 = rate[3],rate[2],rate[1],rate[0]
  - b4 = 0
  - b5..b16 = length[0]..length[11]
  - b17 = even parity of b0..b16
  - b18..b23 = 0
  - SIGNAL is not scrambled: scr_en=0.
  - scr_rst pulses in the cycle of the 24th beat.
- SERVICE: 16 zero bits, scrambled.
- PSDU:
  - byte_ready is high while the internal 8-bit shift register is empty, or on its last bit with bit_ready high. This gives back-to-back bytes without bubbles.
  - If no byte is available, bit_valid=0 (stall). The scrambler does not advance during a stall.
- TAIL: 6 zero bits with tail_zero=1.
- PAD:
  - n_pad zero bits, scrambled.
  - If n_pad==0, go directly from the last TAIL beat to DONE.
- DONE: done pulses for one cycle, busy drops, and the state returns to IDLE. n_pad and n_sym hold.
- Handshake:
  - bit_out must be stable while bit_valid&!bit_ready.
  - Counters advance only on beats.
  - bit_valid stays high in SIGNAL/SERVICE/TAIL/PAD.
- Total beats per frame = 24 + n_sym·N_DBPS.
- Reset mid-frame: IDLE on the next edge, with no done and no err. Partial state is discarded.

Test Plan:
- rate=1101, length=100 → n_sym=35, n_pad=18. SIGNAL bits = 1,1,0,1,0, then 0,0,1,0,0,1,1,0,0,0,0,0, then parity 0, then 000000. Beats=864, and done pulses once.
- rate=0011, length=1, byte 0xA5 → n_sym=1, n_pad=186. PSDU bits are 1,0,1,0,0,1,0,1. scr_rst pulses on beat 24. tail_zero is high for exactly 6 beats.
- rate=1011, length=18, bit_ready toggled pseudo-randomly → n_pad=122. The beat sequence is identical to the run with bit_ready tied high, and bit_out holds while stalled.
- Same frame as above, but byte_valid dropped for 5 cycles mid-PSDU → bit_valid=0 for those cycles, scr_en=0, and the bit stream is unchanged.
- start with rate=0000, then start with length=0 → err pulses for each, busy stays 0, and no beats occur.
- reset asserted on the 50th PSDU beat, then a new start with rate=0101, length=10 → clean frame with n_sym=3, n_pad=42, and no spurious done.

Source files
------------

// File: rtl/tx_frame_sequencer_if.sv
// Byte-in / bit-out streaming handshakes of the 802.11a TX sequencer.
// master = sequencer side, slave = source/sink side.
interface tx_frame_sequencer_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;
  logic       bit_out;
  logic       bit_valid;
  logic       bit_ready;

  modport master (
    input  byte_in,
    input  byte_valid,
    input  bit_ready,
    output byte_ready,
    output bit_out,
    output bit_valid
  );

  modport slave (
    output byte_in,
    output byte_valid,
    output bit_ready,
    input  byte_ready,
    input  bit_out,
    input  bit_valid
  );
endinterface

// File: rtl/tx_frame_sequencer.sv
// 802.11a TX front-end: sizes the frame (N_SYM/N_PAD) and serialises
// SIGNAL, SERVICE, PSDU, TAIL and PAD bits with scrambler controls.
module tx_frame_sequencer #(
  parameter int MAX_LEN = 4095,
  parameter int CNT_W   = 16
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  rate,
  input  logic [11:0] length,
  tx_frame_sequencer_if.master bus,
  output logic        scr_rst,
  output logic        scr_en,
  output logic        tail_zero,
  output logic [7:0]  n_pad,
  output logic [10:0] n_sym,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_SIG,
    S_SVC,
    S_PSDU,
    S_TAIL,
    S_PAD,
    S_DONE
  } state_t;

  function automatic logic [7:0] dbps(
    input logic [3:0] c
  );
    logic [7:0] d;
    case (c)
      4'b1101: d = 8'd24;
      4'b1111: d = 8'd36;
      4'b0101: d = 8'd48;
      4'b0111: d = 8'd72;
      4'b1001: d = 8'd96;
      4'b1011: d = 8'd144;
      4'b0001: d = 8'd192;
      4'b0011: d = 8'd216;
      default: d = 8'd0;
    endcase
    return d;
  endfunction

  state_t r_state;
  state_t w_state_nx;

  logic [3:0]       r_rate;
  logic [11:0]      r_len;
  logic [CNT_W-1:0] r_nbits;
  logic [CNT_W-1:0] r_acc;
  logic [10:0]      r_nsym;
  logic [7:0]       r_npad;
  logic [10:0]      r_nsymo;
  logic [23:0]      r_sig;
  logic [7:0]       r_cnt;
  logic [7:0]       r_sh;
  logic [3:0]       r_shcnt;
  logic [11:0]      r_blft;
  logic             r_err;

  logic [7:0]       w_dbps_in;
  logic [7:0]       w_dbps;
  logic             w_req_ok;
  logic             w_accept;
  logic [CNT_W-1:0] w_acc_nx;
  logic [CNT_W-1:0] w_nbits;
  logic             w_hit;
  logic [23:0]      w_sig;
  logic             w_valid;
  logic             w_bit;
  logic             w_beat;
  logic             w_bready;
  logic             w_take;

  assign w_dbps_in = dbps(rate);
  assign w_dbps    = dbps(r_rate);
  assign w_req_ok  = (w_dbps_in != 8'd0)
                  && (length != 12'd0)
                  && ({20'd0, length} <= 32'(MAX_LEN));
  assign w_accept  = (r_state == S_IDLE) && start && w_req_ok;
  assign w_nbits   = CNT_W'(22) + CNT_W'({length, 3'b000});
  assign w_acc_nx  = r_acc + CNT_W'(w_dbps);
  assign w_hit     = (w_acc_nx >= r_nbits);
  assign w_take    = bus.byte_valid && w_bready;

  // SIGNAL field, bit index = transmit order
  always_comb begin
    w_sig        = '0;
    w_sig[0]     = r_rate[3];
    w_sig[1]     = r_rate[2];
    w_sig[2]     = r_rate[1];
    w_sig[3]     = r_rate[0];
    w_sig[16:5]  = r_len;
    w_sig[17]    = ^w_sig[16:0];
  end

  always_comb begin
    w_state_nx = r_state;
    w_valid    = 1'b0;
    w_bit      = 1'b0;
    scr_rst    = 1'b0;
    tail_zero  = (r_state == S_TAIL);
    busy       = (r_state != S_IDLE);
    done       = (r_state == S_DONE);

    unique case (r_state)
      S_SIG: begin
        w_valid = 1'b1;
        w_bit   = r_sig[0];
      end
      S_SVC, S_TAIL, S_PAD: w_valid = 1'b1;
      S_PSDU: begin
        w_valid = (r_shcnt != 4'd0);
        w_bit   = (r_shcnt != 4'd0) & r_sh[0];
      end
      default: ;
    endcase

    w_beat = w_valid && bus.bit_ready;

    // the first byte is fetched during SERVICE so PSDU starts full
    w_bready = ((r_state == S_SVC) || (r_state == S_PSDU))
            && (r_blft != 12'd0)
            && ((r_shcnt == 4'd0)
             || ((r_state == S_PSDU) && (r_shcnt == 4'd1)
                 && bus.bit_ready));

    scr_en = w_beat && ((r_state == S_SVC) || (r_state == S_PSDU)
                     || (r_state == S_TAIL) || (r_state == S_PAD));

    unique case (r_state)
      S_IDLE: if (w_accept) w_state_nx = S_CALC;
      S_CALC: if (w_hit) w_state_nx = S_SIG;
      S_SIG: begin
        if (w_beat && (r_cnt == 8'd23)) begin
          scr_rst    = 1'b1;
          w_state_nx = S_SVC;
        end
      end
      S_SVC: if (w_beat && (r_cnt == 8'd15)) w_state_nx = S_PSDU;
      S_PSDU: begin
        if (w_beat && (r_shcnt == 4'd1) && (r_blft == 12'd0))
          w_state_nx = S_TAIL;
      end
      S_TAIL: begin
        if (w_beat && (r_cnt == 8'd5))
          w_state_nx = (r_npad == 8'd0) ? S_DONE : S_PAD;
      end
      S_PAD: begin
        if (w_beat && (r_cnt == r_npad - 8'd1))
          w_state_nx = S_DONE;
      end
      S_DONE: w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      r_rate  <= '0;
      r_len   <= '0;
      r_nbits <= '0;
      r_acc   <= '0;
      r_nsym  <= '0;
      r_npad  <= '0;
      r_nsymo <= '0;
      r_sig   <= '0;
      r_cnt   <= '0;
      r_sh    <= '0;
      r_shcnt <= '0;
      r_blft  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= (r_state == S_IDLE) && start && !w_req_ok;

      if (w_state_nx != r_state) r_cnt <= 8'd0;
      else if (w_beat)           r_cnt <= r_cnt + 8'd1;

      if (w_accept) begin
        r_rate  <= rate;
        r_len   <= length;
        r_nbits <= w_nbits;
        r_acc   <= '0;
        r_nsym  <= '0;
        r_blft  <= length;
        r_shcnt <= 4'd0;
      end

      if (r_state == S_CALC) begin
        r_acc  <= w_acc_nx;
        r_nsym <= r_nsym + 11'd1;
        if (w_hit) begin
          r_npad  <= 8'(w_acc_nx - r_nbits);
          r_nsymo <= r_nsym + 11'd1;
          r_sig   <= w_sig;
        end
      end

      if ((r_state == S_SIG) && w_beat)
        r_sig <= {1'b0, r_sig[23:1]};

      if (w_take) begin
        r_sh    <= bus.byte_in;
        r_shcnt <= 4'd8;
        r_blft  <= r_blft - 12'd1;
      end else if ((r_state == S_PSDU) && w_beat) begin
        r_sh    <= {1'b0, r_sh[7:1]};
        r_shcnt <= r_shcnt - 4'd1;
      end
    end
  end

  assign bus.bit_out    = w_bit;
  assign bus.bit_valid  = w_valid;
  assign bus.byte_ready = w_bready;
  assign n_pad          = r_npad;
  assign n_sym          = r_nsymo;
  assign err            = r_err;

endmodule

// File: tb/tb_tx_frame_sequencer.sv
// Directed bench for tx_frame_sequencer: frame sizing, bit order,
// stalls, byte gaps, rejected requests and mid-frame reset.
module tb_tx_frame_sequencer;

  logic        Clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  rate;
  logic [11:0] length;
  logic        scr_rst, scr_en, tail_zero;
  logic [7:0]  n_pad;
  logic [10:0] n_sym;
  logic        busy, done, err;

  always #5 Clk = ~Clk;

  tx_frame_sequencer_if bus();

  tx_frame_sequencer dut (
    .Clk       (Clk),
    .reset     (reset),
    .start     (start),
    .rate      (rate),
    .length    (length),
    .bus       (bus),
    .scr_rst   (scr_rst),
    .scr_en    (scr_en),
    .tail_zero (tail_zero),
    .n_pad     (n_pad),
    .n_sym     (n_sym),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input longint got,
                       input longint want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", tag, got, want);
  endtask

  bit q[$];
  int nbeats, sen_cnt, sen_bad, tail_cnt, rst_beat;
  int done_cnt, err_cnt, busy_cnt, idle_cyc, hold_bad, byte_idx;
  bit hold_pend, hold_bit;

  always @(negedge Clk) begin
    if (bus.bit_valid && bus.bit_ready) begin
      q.push_back(bus.bit_out);
      nbeats++;
      if (tail_zero) tail_cnt++;
    end
    if (scr_rst) rst_beat = nbeats;
    if (scr_en) sen_cnt++;
    if (scr_en && !(bus.bit_valid && bus.bit_ready)) sen_bad++;
    if (hold_pend && !(bus.bit_valid && bus.bit_out == hold_bit))
      hold_bad++;
    hold_pend = bus.bit_valid && !bus.bit_ready;
    hold_bit  = bus.bit_out;
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (busy) busy_cnt++;
    if (busy && !bus.bit_valid) idle_cyc++;
    if (bus.byte_valid && bus.byte_ready) byte_idx++;
  end

  task automatic clr_mon();
    q.delete();
    nbeats = 0; sen_cnt = 0; sen_bad = 0; tail_cnt = 0;
    rst_beat = 0; done_cnt = 0; err_cnt = 0; busy_cnt = 0;
    idle_cyc = 0; hold_bad = 0; byte_idx = 0; hold_pend = 0;
  endtask

  function automatic logic [7:0] dbyte(input int i);
    return 8'hA5 ^ 8'(i * 59);
  endfunction

  task automatic run_frame(input string nm, input logic [3:0] rt,
                           input logic [11:0] ln, input int xsym,
                           input int xpad, input int xdbps,
                           input bit rnd, input bit gap,
                           input int abort_at);
    bit         xq[$];
    bit         poked, gap_done, fin;
    int         gap_left, errs;
    logic [23:0] sig;
    logic [7:0]  b;
    poked = 0; gap_done = 0; fin = 0; gap_left = 0;
    clr_mon();
    @(posedge Clk); #1;
    start = 1'b1; rate = rt; length = ln;
    bus.bit_ready = 1'b1; bus.byte_valid = 1'b0;
    @(posedge Clk); #1;
    start = 1'b0;
    for (int c = 0; c < 8000 && !fin; c++) begin
      @(posedge Clk); #1;
      start = 1'b0;
      if (done_cnt > 0) fin = 1;
      if (abort_at > 0 && nbeats >= abort_at) begin
        reset = 1'b1;
        fin = 1;
      end
      if (!fin) begin
        bus.bit_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (nbeats >= 100 && !poked) begin
          start = 1'b1; rate = 4'b0000; poked = 1;
        end
        #1;
        if (gap && !gap_done && gap_left == 0 && byte_idx == 9
            && bus.byte_ready)
          gap_left = 5;
        if (gap_left > 0) begin
          bus.byte_valid = 1'b0;
          gap_left--;
          if (gap_left == 0) gap_done = 1;
        end else begin
          bus.byte_valid = (byte_idx < int'(ln));
        end
        bus.byte_in = dbyte(byte_idx);
      end
    end
    check({nm, "/finished"}, fin, 1);
    if (abort_at > 0) begin
      @(posedge Clk); #1;
      reset = 1'b0;
      bus.byte_valid = 1'b0;
      @(negedge Clk);
      check({nm, "/busy_after_rst"}, busy, 0);
      check({nm, "/valid_after_rst"}, bus.bit_valid, 0);
      check({nm, "/no_done"}, done_cnt, 0);
      check({nm, "/no_err"}, err_cnt, 0);
      return;
    end
    sig = '0;
    sig[0] = rt[3]; sig[1] = rt[2]; sig[2] = rt[1]; sig[3] = rt[0];
    sig[16:5] = ln;
    sig[17] = ^sig[16:0];
    for (int i = 0; i < 24; i++) xq.push_back(sig[i]);
    repeat (16) xq.push_back(1'b0);
    for (int i = 0; i < int'(ln); i++) begin
      b = dbyte(i);
      for (int j = 0; j < 8; j++) xq.push_back(b[j]);
    end
    repeat (6) xq.push_back(1'b0);
    repeat (xpad) xq.push_back(1'b0);
    errs = 0;
    for (int i = 0; i < xq.size(); i++)
      if (i >= q.size() || q[i] != xq[i]) errs++;
    check({nm, "/beats"}, nbeats, 24 + xsym * xdbps);
    check({nm, "/stream_errs"}, errs, 0);
    check({nm, "/n_sym"}, n_sym, xsym);
    check({nm, "/n_pad"}, n_pad, xpad);
    check({nm, "/done_pulses"}, done_cnt, 1);
    check({nm, "/busy_end"}, busy, 0);
    check({nm, "/err_pulses"}, err_cnt, 0);
    check({nm, "/tail_beats"}, tail_cnt, 6);
    check({nm, "/scr_rst_beat"}, rst_beat, 24);
    check({nm, "/scr_en_cnt"}, sen_cnt, nbeats - 24);
    check({nm, "/scr_en_bad"}, sen_bad, 0);
    check({nm, "/hold_bad"}, hold_bad, 0);
    check({nm, "/idle_cyc"}, idle_cyc, xsym + 1 + (gap ? 5 : 0));
  endtask

  logic [0:23] lit1;
  logic [0:7]  lit2;
  logic [20:0] rst_vec;
  int          e;

  initial begin
    reset = 1'b1; start = 1'b0; rate = '0; length = '0;
    bus.byte_in = '0; bus.byte_valid = 1'b0; bus.bit_ready = 1'b1;
    clr_mon();
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    rst_vec = {bus.byte_ready, bus.bit_out, bus.bit_valid, scr_rst,
               scr_en, tail_zero, busy, done, err, n_pad[3:0],
               n_sym[7:0]};
    check("reset_outs", rst_vec, 0);
    check("reset_npad", n_pad, 0);
    check("reset_nsym", n_sym, 0);
    @(posedge Clk); #1;
    reset = 1'b0;

    run_frame("f1", 4'b1101, 12'd100, 35, 18, 24, 0, 0, 0);
    lit1 = 24'b110100010011000000000000;
    e = 0;
    for (int i = 0; i < 24; i++)
      if (q.size() <= i || q[i] != lit1[i]) e++;
    check("f1/sig_bits", e, 0);

    run_frame("f2", 4'b0011, 12'd1, 1, 186, 216, 0, 0, 0);
    lit2 = 8'b10100101;
    e = 0;
    for (int i = 0; i < 8; i++)
      if (q.size() <= 40 + i || q[40 + i] != lit2[i]) e++;
    check("f2/psdu_bits", e, 0);

    run_frame("f3_stall", 4'b1011, 12'd18, 2, 122, 144, 1, 0, 0);
    run_frame("f4_gap", 4'b1011, 12'd18, 2, 122, 144, 0, 1, 0);

    clr_mon();
    @(posedge Clk); #1;
    start = 1'b1; rate = 4'b0000; length = 12'd5;
    @(posedge Clk); #1;
    start = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check("badrate/err", err_cnt, 1);
    check("badrate/busy", busy_cnt, 0);
    check("badrate/beats", nbeats, 0);

    clr_mon();
    start = 1'b1; rate = 4'b1101; length = 12'd0;
    @(posedge Clk); #1;
    start = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check("len0/err", err_cnt, 1);
    check("len0/busy", busy_cnt, 0);
    check("len0/beats", nbeats, 0);

    run_frame("abort", 4'b1101, 12'd100, 35, 18, 24, 0, 0, 89);
    run_frame("f5", 4'b0101, 12'd10, 3, 42, 48, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
